// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the 4-digit FND scan path.
package fnd_pkg;

    localparam int FND_DIGITS = 4;
    localparam int PLACE_W    = 2;
    localparam int VAL_W      = 9;

    localparam logic [FND_DIGITS-1:0] COM_OFF = 4'b1111;

    // Decimal weight of each digit place, one bit wider than the value so
    // that 1000 fits and comparisons against a zero-extended value are exact.
    localparam logic [VAL_W:0] POW10 [FND_DIGITS] = '{10'd1, 10'd10, 10'd100, 10'd1000};

    typedef logic [PLACE_W-1:0] place_t;

    // A place above the ones digit is a leading zero when the value has no
    // nonzero digit at or above that place, i.e. value < 10^place.
    function automatic logic place_blanked(input logic [VAL_W-1:0] value, input place_t place);
        if (place == '0) begin
            return 1'b0;
        end
        return ({1'b0, value} < POW10[place]);
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_prescaler.sv
// Slot prescaler: counts SCAN_DIV enabled cycles and flags the last one.
module scan_prescaler #(
    parameter int SCAN_DIV = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    output logic [$clog2(SCAN_DIV)-1:0] cnt,
    output logic                        tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: advance while enabled, wrap after the last cycle of a slot, hold otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// FND scan controller: place counter, frame-coherent value latch and
// active-low digit commons with dead time and leading-zero blanking.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DEAD_CYC = 16,
    parameter int LZ_BLANK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [VAL_W-1:0] value_in,
    output logic [VAL_W-1:0] value_out,
    output logic [1:0]       sel_place,
    output logic [3:0]       fnd_com,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC);

    logic [CNT_W-1:0] cnt;
    logic             tick;

    place_t           place_q;
    place_t           place_d;
    logic [VAL_W-1:0] value_q;
    logic [VAL_W-1:0] value_d;
    logic             frame_done_q;
    logic             frame_done_d;
    logic             blanked;

    scan_prescaler #(
        .SCAN_DIV(SCAN_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .cnt (cnt),
        .tick(tick)
    );

    // Next place/value/pulse: step the place on each slot tick; the wrap from
    // the thousands place back to ones closes a frame and latches the new value.
    always_comb begin
        place_d      = place_q;
        value_d      = value_q;
        frame_done_d = 1'b0;
        if (tick) begin
            place_d = place_q + 2'd1;
            if (place_q == 2'd3) begin
                value_d      = value_in;
                frame_done_d = 1'b1;
            end
        end
    end

    // Scan state registers, returned to place 0 / value 0 immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            place_q      <= '0;
            value_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            place_q      <= place_d;
            value_q      <= value_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Commons are driven only outside the dead window of an enabled, non-blanked slot.
    always_comb begin
        blanked = (LZ_BLANK != 0) && place_blanked(value_q, place_q);
        fnd_com = COM_OFF;
        if (en && (cnt >= DEAD_LAST) && !blanked) begin
            fnd_com = ~(4'b0001 << place_q);
        end
    end

    assign value_out  = value_q;
    assign sel_place  = place_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl with SCAN_DIV=8, DEAD_CYC=2, run
// side by side with and without leading-zero blanking.
module tb_fnd_scan_ctrl;

    localparam int SDIV  = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * SDIV;

    logic       clk;
    logic       rst;
    logic       en;
    logic [8:0] value_in;

    logic [8:0] valueOutN, valueOutB;
    logic [1:0] selPlaceN, selPlaceB;
    logic [3:0] fndComN, fndComB;
    logic       frameDoneN, frameDoneB;

    int assertCount;
    int failCount;
    int frameSeen;

    // Reference model state: number of enabled clock edges since reset,
    // the value latched at the last frame boundary, and the pulse flag.
    int         enCycles;
    int         modelValue;
    int         modelDone;

    fnd_scan_ctrl #(.SCAN_DIV(SDIV), .DEAD_CYC(DEAD), .LZ_BLANK(0)) dutNoBlank (
        .clk(clk), .rst(rst), .en(en), .value_in(value_in),
        .value_out(valueOutN), .sel_place(selPlaceN), .fnd_com(fndComN), .frame_done(frameDoneN)
    );

    fnd_scan_ctrl #(.SCAN_DIV(SDIV), .DEAD_CYC(DEAD), .LZ_BLANK(1)) dutBlank (
        .clk(clk), .rst(rst), .en(en), .value_in(value_in),
        .value_out(valueOutB), .sel_place(selPlaceB), .fnd_com(fndComB), .frame_done(frameDoneB)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Expected commons from the display rules: off when disabled, in the
    // dead window, or when the digit at this place is a leading zero.
    function automatic int expCom(input int lz, input int enNow);
        int place;
        int slotPos;
        int pow;
        place   = (enCycles / SDIV) % 4;
        slotPos = enCycles % SDIV;
        pow     = 1;
        for (int k = 0; k < place; k++) pow = pow * 10;
        if (enNow == 0 || slotPos < DEAD) return 15;
        if (lz != 0 && place > 0 && modelValue < pow) return 15;
        return 15 - (1 << place);
    endfunction

    task automatic modelReset();
        enCycles   = 0;
        modelValue = 0;
        modelDone  = 0;
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic modelEdge(input logic e, input logic [8:0] v);
        modelDone = 0;
        if (e) begin
            enCycles++;
            if (enCycles % FRAME == 0) begin
                modelValue = v;
                modelDone  = 1;
            end
        end
    endtask

    task automatic compareAll(input string tag);
        int expPlace;
        expPlace = (enCycles / SDIV) % 4;
        checkOutput({tag, ".selN"}, selPlaceN, expPlace);
        checkOutput({tag, ".selB"}, selPlaceB, expPlace);
        checkOutput({tag, ".valN"}, valueOutN, modelValue);
        checkOutput({tag, ".valB"}, valueOutB, modelValue);
        checkOutput({tag, ".doneN"}, frameDoneN, modelDone);
        checkOutput({tag, ".doneB"}, frameDoneB, modelDone);
        checkOutput({tag, ".comN"}, fndComN, expCom(0, int'(en)));
        checkOutput({tag, ".comB"}, fndComB, expCom(1, int'(en)));
        if (frameDoneB === 1'b1) frameSeen++;
    endtask

    // Hold en/value for n clock edges, checking every cycle 1 unit after the edge.
    task automatic applyStimulus(input string tag, input logic e, input logic [8:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            en       = e;
            value_in = v;
            @(posedge clk);
            modelEdge(e, v);
            #1;
            compareAll(tag);
        end
    endtask

    // Assert reset between edges and check that outputs clear without a clock.
    task automatic pulseReset(input string tag);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput({tag, ".rstSel"}, selPlaceB, 0);
        checkOutput({tag, ".rstVal"}, valueOutB, 0);
        checkOutput({tag, ".rstDone"}, frameDoneB, 0);
        checkOutput({tag, ".rstCom"}, fndComB, 15);
        compareAll(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic       rEn;
        logic [8:0] rVal;
        assertCount = 0;
        failCount   = 0;
        frameSeen   = 0;
        rst         = 1'b1;
        en          = 1'b0;
        value_in    = 9'd0;
        modelReset();
        @(posedge clk);
        #1;
        compareAll("init");
        rst = 1'b0;

        // First tick lands after SCAN_DIV enabled cycles.
        applyStimulus("first", 1'b1, 9'd345, SDIV);
        checkOutput("firstTick", selPlaceB, 1);

        // Reset in the middle of a slot, then full scan with value 345.
        applyStimulus("pre", 1'b1, 9'd345, 3);
        pulseReset("midRst");
        applyStimulus("scan345", 1'b1, 9'd345, FRAME);
        checkOutput("frame32Done", frameDoneN, 1);
        checkOutput("frame32Val", valueOutN, 345);
        applyStimulus("scan345b", 1'b1, 9'd345, DEAD);
        checkOutput("place0Com", fndComN, 14);
        applyStimulus("scan345c", 1'b1, 9'd345, FRAME);

        // Leading-zero blanking for a few representative values.
        pulseReset("rst7");
        applyStimulus("lz7", 1'b1, 9'd7, 2 * FRAME);
        pulseReset("rst0");
        applyStimulus("lz0", 1'b1, 9'd0, 2 * FRAME);
        pulseReset("rst100");
        applyStimulus("lz100", 1'b1, 9'd100, FRAME + 3 * SDIV + DEAD);
        checkOutput("lz100Place3", fndComB, 15);
        checkOutput("lz100Place3N", fndComN, 7);

        // Frame coherency: mid-frame change waits for the wrap.
        pulseReset("rstCoh");
        applyStimulus("coh123", 1'b1, 9'd123, FRAME + 2 * SDIV);
        applyStimulus("coh456", 1'b1, 9'd456, 2 * SDIV - 1);
        checkOutput("cohHold", valueOutB, 123);
        applyStimulus("cohWrap", 1'b1, 9'd456, 1);
        checkOutput("cohNew", valueOutB, 456);
        checkOutput("cohDone", frameDoneB, 1);

        // Enable gating at cnt=5 of place 1.
        pulseReset("rstEn");
        applyStimulus("enRun", 1'b1, 9'd42, SDIV + 5);
        applyStimulus("enOff", 1'b0, 9'd42, 10);
        checkOutput("enFrozen", selPlaceB, 1);
        applyStimulus("enOn", 1'b1, 9'd42, 2);
        checkOutput("enPreTick", selPlaceB, 1);
        applyStimulus("enTick", 1'b1, 9'd42, 1);
        checkOutput("enPlace2", selPlaceB, 2);

        // Three continuous frames of 511.
        pulseReset("rst511");
        frameSeen = 0;
        applyStimulus("run511", 1'b1, 9'd511, 3 * FRAME);
        checkOutput("frames511", frameSeen, 3);

        // Randomized enable, value and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulseReset("rndRst");
            end
            rEn  = ($urandom_range(0, 7) != 0);
            rVal = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0) rVal = 9'($urandom_range(0, 15));
            applyStimulus("rnd", rEn, rVal, int'($urandom_range(1, 6)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
